// File: rtl/wb_stage_mlane.sv
// wb_stage_mlane: multi-lane write-back stage that retires one lane per cycle in lane order and forwards pending results
module wb_stage_mlane #(
  parameter int LANES = 2,
  parameter int PC_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_W = 5,
  localparam int LANE_W = 2 + PC_W + REG_W + DATA_W,
  localparam int FWD_W = 1 + REG_W + DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    ws_allowin,
  input  logic                    ms_to_ws_valid,
  input  logic [LANES*LANE_W-1:0] ms_to_ws_bus,
  output logic [FWD_W-1:0]        ws_to_rf_bus,
  output logic                    ws_to_ds_valid,
  output logic [LANES*FWD_W-1:0]  ws_to_ds_fwd_bus,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);
  localparam int SW = LANE_W - 1;
  logic ws_valid, retiring, ret_we, ws_ready_go;
  logic [LANES-1:0] pending, in_v, ret_oh;
  logic [LANES*SW-1:0] grp, grp_d;
  logic [SW-1:0] ret;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic fv;
    assign in_v[i] = ms_to_ws_bus[i*LANE_W+SW];
    assign grp_d[i*SW +: SW] = ms_to_ws_bus[i*LANE_W +: SW];
    assign fv = ws_valid && pending[i] && grp[i*SW+DATA_W+REG_W] && |grp[i*SW+DATA_W +: REG_W];
    assign ws_to_ds_fwd_bus[i*FWD_W +: FWD_W] = fv ? {1'b1, grp[i*SW +: DATA_W+REG_W]} : '0;
  end
  always_comb begin
    ret_oh = '0;
    ret = '0;
    for (int i = LANES - 1; i >= 0; i--)
      if (pending[i]) begin
        ret_oh = '0;
        ret_oh[i] = 1'b1;
        ret = grp[i*SW +: SW];
      end
  end
  assign retiring = ws_valid && |pending;
  assign ret_we = retiring && ret[DATA_W+REG_W] && |ret[DATA_W +: REG_W];
  assign ws_ready_go = (pending & (pending - LANES'(1))) == '0;
  assign ws_allowin = !ws_valid || ws_ready_go;
  assign ws_to_ds_valid = ws_valid;
  assign ws_to_rf_bus = retiring ? {ret_we, ret[DATA_W+REG_W-1:0]} : '0;
  assign debug_wb_pc = retiring ? 32'(ret[SW-1 -: PC_W]) : '0;
  assign debug_wb_rf_wen = {4{ret_we}};
  assign debug_wb_rf_wnum = retiring ? 5'(ret[DATA_W +: REG_W]) : '0;
  assign debug_wb_rf_wdata = retiring ? 32'(ret[DATA_W-1:0]) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid <= 1'b0;
      pending <= '0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid;
      pending <= ms_to_ws_valid ? in_v : '0;
    end else
      pending <= pending & ~ret_oh;
  end
  always_ff @(posedge clk)
    if (ws_allowin && ms_to_ws_valid) grp <= grp_d;
endmodule

// File: doc/wb_stage_mlane.md
# wb_stage_mlane

Parametrised write-back stage for multi-issue configurations of the CPU pipeline. It accepts a group of up to LANES retiring instructions per handshake from the memory stage. It retires them strictly in lane order (lane 0 oldest), one per cycle, to a single register-file write port and to the single-commit trace debug interface. While a group drains, it back-pressures the memory stage and forwards every not-yet-written result to the decode stage.

## Interface
Parameters:
- LANES, 2, lanes per group (1..4); LANES=1 degenerates to a single-issue stage with a pipeline register
- PC_W, 32, PC width
- DATA_W, 32, result width
- REG_W, 5, register-number width
- Derived: LANE_W = 2+PC_W+REG_W+DATA_W; FWD_W = 1+REG_W+DATA_W

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- ws_allowin  out  1  stage can accept a group this cycle
- ms_to_ws_valid  in  1  group offered by memory stage
- ms_to_ws_bus  in  LANES*LANE_W  lane i at [i*LANE_W +: LANE_W], fields MSB→LSB {lane_v, pc, we, dest, result}
- ws_to_rf_bus  out  FWD_W  {rf_we, rf_waddr, rf_wdata}
- ws_to_ds_valid  out  1  stage holds a group (ws_valid)
- ws_to_ds_fwd_bus  out  LANES*FWD_W  per lane {fwd_v, dest, result} at [i*FWD_W +: FWD_W]
- debug_wb_pc  out  32  PC of retiring lane, zero-extended or truncated to 32
- debug_wb_rf_wen  out  4  {4{retiring lane's effective we}}
- debug_wb_rf_wnum  out  5  dest of retiring lane
- debug_wb_rf_wdata  out  32  result of retiring lane

## Operation
- State: ws_valid, group register (LANES×LANE_W), pending[LANES].
- Load: when ms_to_ws_valid && ws_allowin, capture the bus and set pending[i]=lane_v[i], ws_valid=1. If ms_to_ws_valid=0 while ws_allowin=1, set ws_valid=0 and pending=0.
- Retire select: ret_idx = lowest i with pending[i]=1. Retire happens each cycle ws_valid && |pending. The retired lane's pending bit clears at the edge.
- ws_ready_go = (pending has ≤1 bit set); the last lane retires in the same cycle the next group loads.
- ws_allowin = !ws_valid || ws_ready_go.
- Effective we = lane we && dest≠0. Lanes with we=0 still retire (one cycle, debug wen=0, PC shown).
- Groups with all lane_v=0 occupy the stage for exactly one cycle with no retire.
- RF bus: rf_we = retiring && effective we; addr/data from the retiring lane. All fields are 0 when not retiring.
- Debug: all four outputs come from the retiring lane. When no retire: pc=0, wen=0, wnum=0, wdata=0.
- Forward bus: fwd_v[i] = ws_valid && pending[i] && lane we && dest≠0. This includes the lane retiring this cycle. If several lanes hit the same dest, decode picks the highest index (youngest).

## Timing
- All outputs combinational from registered state; no input→output combinational path except ws_allowin→(loaded next edge).
- Latency: group accepted at edge T; lane k-th valid (0-based among valid lanes) retires in cycle T+1+k.
- Throughput: one group per max(1, popcount(lane_v)) cycles; a full LANES-lane group blocks ws_allowin for LANES−1 cycles.
- Reset (any cycle, including mid-drain): ws_valid=0, pending=0 next edge. Outputs after reset: ws_allowin=1, ws_to_ds_valid=0, all buses 0, debug outputs 0. Un-retired lanes are discarded.
- Simultaneous last-retire and new load: the retire of the old lane is visible this cycle; the new group's first lane retires next cycle with no bubble.

## Test plan
- Reset mid-drain: LANES=2, load {pc 0x1c000000 we dest 3 data 0x11, pc 0x1c000004 we dest 4 data 0x22}, assert reset after first retire → lane 1 never appears on debug; outputs are all 0 and ws_allowin=1 the cycle after reset.
- Full group: same group with no reset → cycle T+1 debug pc 0x1c000000 wen 4'hf wnum 3 wdata 0x11, ws_allowin=0. Cycle T+2 pc 0x1c000004 wnum 4 wdata 0x22, ws_allowin=1.
- Back-to-back: ms_to_ws_valid held high with three 2-lane groups → 6 consecutive retire cycles in PC order, no bubbles, allowin toggles 0/1.
- Sparse/empty groups: lane_v=2'b10 → single retire of lane 1 in T+1, allowin stays 1. lane_v=2'b00 → no retire (wen=0, pc=0), ws_to_ds_valid=1 for one cycle.
- r0 and we=0: dest 0 with we=1 → rf_we=0, debug wen=0, fwd_v=0, PC still shown. A we=0 lane still consumes one cycle.
- Forwarding: group with both lanes writing dest 5 (0xA, 0xB) → in T+1 both fwd_v=1. In T+2 only lane 1 fwd_v=1. In T+3 both 0.
